economy_unit: RTL and testbench

ECONOMY_UNIT -- requirements
Module: economy_unit

---
 rtl/economy_unit_pkg.sv | 18 +
 rtl/economy_unit_click.sv | 14 +
 rtl/economy_unit.sv | 103 ++++++++++
 tb/tb_economy_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/economy_unit_pkg.sv
// economy_unit_pkg: shared state type, price tables and money helpers for economy_unit
package economy_unit_pkg;
  localparam int MONEY_W = 15;
  localparam int DEF_TOWER_CNT_MAX = 150;
  typedef enum logic [1:0] {IDLE, RUN, SPAWN} state_e;
  typedef logic [MONEY_W-1:0] money_t;
  localparam money_t UNIT_COST [8] = '{15'd75, 15'd150, 15'd240, 15'd350,
                                       15'd750, 15'd1500, 15'd2000, 15'd2400};
  function automatic money_t income(input logic [2:0] lvl);
    return money_t'(lvl) + 15'd2;
  endfunction
  function automatic money_t money_cap(input logic [2:0] lvl);
    return 15'd1000 + 15'd500 * money_t'(lvl);
  endfunction
  function automatic money_t upgrade_cost(input logic [2:0] lvl);
    return 15'd100 + 15'd100 * money_t'(lvl);
  endfunction
endpackage

// File: rtl/economy_unit_click.sv
// click_edge: rising-edge detector for the raw mouse button
//   clk_i, rst_n_i (sync active-low), clr_i (forget previous level), lvl_i (raw), rise_o (edge)
module click_edge (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic lvl_i,
  output logic rise_o
);
  logic prev_q;
  always_ff @(posedge clk_i)
    prev_q <= (!rst_n_i || clr_i) ? 1'b0 : lvl_i;
  assign rise_o = lvl_i & ~prev_q;
endmodule

// File: rtl/economy_unit.sv
// economy_unit: money, purse, unit purchase and fire-tower bookkeeping for the game
//   in : clk_25MHz, rst (sync active-low), frame_tick, game_init, game_active,
//        mouse_l, mouse_in_frame[9:0] ([0] purse, [8:1] slots, [9] fire), spawn_ready
//   out: money, purse_level, able_to_upgrade, tower_cnt, spawn_valid, spawn_type, fire_pulse
module economy_unit
  import economy_unit_pkg::*;
#(
  parameter int TOWER_CNT_MAX = DEF_TOWER_CNT_MAX,
  parameter int INCOME_DIV    = 6
) (
  input  logic        clk_25MHz,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        game_init,
  input  logic        game_active,
  input  logic        mouse_l,
  input  logic [9:0]  mouse_in_frame,
  input  logic        spawn_ready,
  output logic [14:0] money,
  output logic [2:0]  purse_level,
  output logic        able_to_upgrade,
  output logic [7:0]  tower_cnt,
  output logic        spawn_valid,
  output logic [2:0]  spawn_type,
  output logic        fire_pulse
);
  state_e state_q, state_d;
  money_t money_q, money_d, cost, cap, raw;
  logic [2:0] level_q, level_d, type_q, type_d, slot;
  logic [7:0] tower_q, tower_d, div_q, div_d;
  logic fire_q, fire_d;
  logic click, one_hot, active, tick, inc_tick, slot_hit, tower_full;
  logic buy_unit, buy_purse, fire;

  click_edge u_click (
    .clk_i  (clk_25MHz),
    .rst_n_i(rst),
    .clr_i  (game_init),
    .lvl_i  (mouse_l),
    .rise_o (click)
  );

  always_comb begin
    one_hot = $onehot(mouse_in_frame);
    active = state_q != IDLE && game_active;
    tick = active && frame_tick;
    slot = 3'd0;
    for (int i = 1; i < 9; i++) if (mouse_in_frame[i]) slot = 3'(i - 1);
    slot_hit = one_hot && |mouse_in_frame[8:1];
    tower_full = tower_q == 8'(TOWER_CNT_MAX);
    inc_tick = tick && div_q == 8'(INCOME_DIV - 1);
    able_to_upgrade = level_q != 3'd7 && money_q >= upgrade_cost(level_q);
    buy_unit = click && slot_hit && state_q == RUN && game_active && money_q >= UNIT_COST[slot];
    buy_purse = click && active && one_hot && mouse_in_frame[0] && able_to_upgrade;
    fire = click && active && one_hot && mouse_in_frame[9] && tower_full;
    cost = buy_unit ? UNIT_COST[slot] : buy_purse ? upgrade_cost(level_q) : '0;
    level_d = level_q + 3'(buy_purse);
    // income uses the level in force this cycle, the cap the level after any upgrade
    cap = money_cap(level_d);
    raw = money_q - cost + (inc_tick ? income(level_q) : '0);
    money_d = raw > cap ? cap : raw;
    div_d = !tick ? div_q : inc_tick ? 8'd0 : div_q + 8'd1;
    tower_d = fire ? 8'd0 : (tick && !tower_full) ? tower_q + 8'd1 : tower_q;
    fire_d = fire;
    type_d = buy_unit ? slot : type_q;
    state_d = buy_unit ? SPAWN : (state_q == SPAWN && spawn_ready) ? RUN : state_q;
    if (!game_active) state_d = IDLE;
    if (game_init) begin
      state_d = RUN;
      money_d = '0;
      level_d = 3'd0;
      tower_d = 8'd0;
      div_d = 8'd0;
      fire_d = 1'b0;
    end
  end

  always_ff @(posedge clk_25MHz)
    if (!rst) begin
      state_q <= IDLE;
      money_q <= '0;
      level_q <= 3'd0;
      type_q <= 3'd0;
      tower_q <= 8'd0;
      div_q <= 8'd0;
      fire_q <= 1'b0;
    end else begin
      state_q <= state_d;
      money_q <= money_d;
      level_q <= level_d;
      type_q <= type_d;
      tower_q <= tower_d;
      div_q <= div_d;
      fire_q <= fire_d;
    end

  assign money = money_q;
  assign purse_level = level_q;
  assign tower_cnt = tower_q;
  assign spawn_valid = state_q == SPAWN;
  assign spawn_type = type_q;
  assign fire_pulse = fire_q;
endmodule

// File: tb/tb_economy_unit.sv
// tb_economy_unit: scoreboard bench for economy_unit against a behavioural model
module tb_economy_unit;
  localparam int TMAX = 150;
  localparam int DIV = 6;
  localparam int COST [8] = '{75, 150, 240, 350, 750, 1500, 2000, 2400};

  typedef struct {
    int money, lvl, able, tower, sv, stype, fp;
  } exp_t;

  logic clk = 0, rst = 0, frame_tick = 0, game_init = 0, game_active = 0, mouse_l = 0, spawn_ready = 0;
  logic [9:0] mif = '0;
  logic [14:0] money;
  logic [2:0] purse_level, spawn_type;
  logic able_to_upgrade, spawn_valid, fire_pulse;
  logic [7:0] tower_cnt;

  int n_tests = 0, n_fail = 0;
  int m_money, m_lvl, m_tower, m_div, m_st, m_type, m_fp, m_prev;
  exp_t sb [$];

  economy_unit #(.TOWER_CNT_MAX(TMAX), .INCOME_DIV(DIV)) dut (
    .clk_25MHz(clk), .rst(rst), .frame_tick(frame_tick), .game_init(game_init),
    .game_active(game_active), .mouse_l(mouse_l), .mouse_in_frame(mif),
    .spawn_ready(spawn_ready), .money(money), .purse_level(purse_level),
    .able_to_upgrade(able_to_upgrade), .tower_cnt(tower_cnt), .spawn_valid(spawn_valid),
    .spawn_type(spawn_type), .fire_pulse(fire_pulse)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic model();
    int hits, k, inc, c, st0, cap;
    bit click;
    hits = 0;
    k = 0;
    for (int i = 0; i < 10; i++) if (mif[i]) begin hits++; k = i; end
    if (!rst) begin
      m_money = 0; m_lvl = 0; m_tower = 0; m_div = 0; m_st = 0; m_type = 0; m_fp = 0; m_prev = 0;
    end else if (game_init) begin
      m_money = 0; m_lvl = 0; m_tower = 0; m_div = 0; m_fp = 0; m_prev = 0; m_st = 1;
    end else if (!game_active) begin
      m_st = 0; m_fp = 0; m_prev = mouse_l;
    end else begin
      click = mouse_l && !m_prev;
      m_prev = mouse_l;
      m_fp = 0;
      inc = 0;
      c = 0;
      st0 = m_st;
      if (st0 != 0) begin
        if (frame_tick) begin
          m_div++;
          if (m_div == DIV) begin m_div = 0; inc = 2 + m_lvl; end
        end
        if (st0 == 2 && spawn_ready) m_st = 1;
        if (click && hits == 1) begin
          if (k == 0) begin
            if (m_lvl < 7 && m_money >= 100 * (m_lvl + 1)) begin c = 100 * (m_lvl + 1); m_lvl++; end
          end else if (k == 9) begin
            if (m_tower == TMAX) m_fp = 1;
          end else if (st0 == 1 && m_money >= COST[k-1]) begin
            c = COST[k-1]; m_st = 2; m_type = k - 1;
          end
        end
        if (m_fp) m_tower = 0;
        else if (frame_tick && m_tower < TMAX) m_tower++;
        cap = 1000 + 500 * m_lvl;
        m_money = m_money - c + inc;
        if (m_money > cap) m_money = cap;
      end
    end
  endtask

  task automatic cyc();
    exp_t e, g;
    model();
    e.money = m_money; e.lvl = m_lvl; e.tower = m_tower; e.sv = int'(m_st == 2);
    e.stype = m_type; e.fp = m_fp; e.able = int'(m_lvl < 7 && m_money >= 100 * (m_lvl + 1));
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check("money", int'(money), g.money);
    check("purse_level", int'(purse_level), g.lvl);
    check("able", int'(able_to_upgrade), g.able);
    check("tower_cnt", int'(tower_cnt), g.tower);
    check("spawn_valid", int'(spawn_valid), g.sv);
    check("spawn_type", int'(spawn_type), g.stype);
    check("fire_pulse", int'(fire_pulse), g.fp);
  endtask

  task automatic ticks(input int n);
    frame_tick = 1;
    repeat (n) cyc();
    frame_tick = 0;
  endtask

  task automatic press(input int region);
    mif = '0;
    mif[region] = 1'b1;
    mouse_l = 1;
    cyc();
  endtask

  task automatic release_btn();
    mouse_l = 0;
    mif = '0;
    cyc();
  endtask

  initial begin
    repeat (2) cyc();
    check("rst_money", int'(money), 0);
    check("rst_sv", int'(spawn_valid), 0);
    rst = 1;
    game_active = 1;
    game_init = 1;
    cyc();
    game_init = 0;
    ticks(12);
    check("lvl0_money4", int'(money), 4);
    check("lvl0_tower12", int'(tower_cnt), 12);
    ticks(228);
    check("money80", int'(money), 80);
    check("tower_sat", int'(tower_cnt), TMAX);
    press(1);
    check("buy1_money", int'(money), 5);
    check("buy1_sv", int'(spawn_valid), 1);
    check("buy1_type", int'(spawn_type), 0);
    release_btn();
    press(2);
    check("spawn_ignore", int'(money), 5);
    release_btn();
    check("sv_held", int'(spawn_valid), 1);
    spawn_ready = 1;
    cyc();
    spawn_ready = 0;
    check("sv_done", int'(spawn_valid), 0);
    ticks(510);
    check("money175", int'(money), 175);
    press(1);
    check("money100", int'(money), 100);
    check("able100", int'(able_to_upgrade), 1);
    spawn_ready = 1;
    release_btn();
    spawn_ready = 0;
    press(0);
    check("up_lvl", int'(purse_level), 1);
    check("up_money", int'(money), 0);
    repeat (49) cyc();
    check("held_lvl", int'(purse_level), 1);
    release_btn();
    game_init = 1;
    cyc();
    game_init = 0;
    check("init_clr", int'(money) + int'(purse_level) + int'(tower_cnt), 0);
    ticks(3000);
    check("money1000", int'(money), 1000);
    press(1);
    check("money925", int'(money), 925);
    spawn_ready = 1;
    release_btn();
    spawn_ready = 0;
    ticks(222);
    check("money999", int'(money), 999);
    ticks(6);
    check("sat1", int'(money), 1000);
    ticks(6);
    check("sat2", int'(money), 1000);
    frame_tick = 1;
    press(9);
    frame_tick = 0;
    check("fire_pulse", int'(fire_pulse), 1);
    check("fire_tower", int'(tower_cnt), 0);
    release_btn();
    check("fire_once", int'(fire_pulse), 0);
    ticks(149);
    press(9);
    check("fire149_pulse", int'(fire_pulse), 0);
    check("fire149_tower", int'(tower_cnt), 149);
    release_btn();
    mif = 10'b0000000110;
    mouse_l = 1;
    cyc();
    check("multihot", int'(money), 1000);
    release_btn();
    game_active = 0;
    cyc();
    ticks(12);
    press(1);
    check("idle_money", int'(money), 1000);
    check("idle_tower", int'(tower_cnt), 149);
    release_btn();
    game_active = 1;
    game_init = 1;
    cyc();
    game_init = 0;
    ticks(228);
    press(3);
    check("unaffordable", int'(money), 76);
    release_btn();
    press(1);
    check("buy_pre_rst", int'(spawn_valid), 1);
    release_btn();
    rst = 0;
    cyc();
    check("rst_sv_mid", int'(spawn_valid), 0);
    check("rst_all", int'(money) + int'(tower_cnt) + int'(purse_level) + int'(spawn_type), 0);
    rst = 1;
    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
